// File: rtl/uart_tx_framer_pkg.sv
// Shared definitions for the UART transmit framer: FSM states, default
// frame parameters and the frame-length helper.
package uart_tx_framer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int unsigned DEF_DATA_BITS = 8;
  localparam int unsigned DEF_STOP_BITS = 1;

  // Frame length: start + data + optional parity + stop bits.
  function automatic int unsigned frame_bits(input int unsigned data_bits,
                                             input int unsigned parity_en,
                                             input int unsigned stop_bits);
    return 1 + data_bits + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_framer_shift.sv
// Frame shift register with parity insertion and tick counter; drives the
// registered serial bit and flags the frame-end tick.
module uart_tx_shift
  import uart_tx_framer_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = DEF_STOP_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 tick,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx_bit,
  output logic                 last
);

  localparam int unsigned NBITS = frame_bits(DATA_BITS, PARITY_EN, STOP_BITS);
  localparam int unsigned CW    = $clog2(NBITS + 1);
  localparam logic [CW-1:0] END_IDX = CW'(NBITS);

  logic [NBITS-1:0] frame;
  logic [NBITS-1:0] frame_init;
  logic [CW-1:0]    cnt;

  always_comb begin
    frame_init    = '1;
    frame_init[0] = 1'b0;
    for (int unsigned i = 0; i < DATA_BITS; i++) begin
      frame_init[i+1] = data[i];
    end
    if (PARITY_EN != 0) begin
      frame_init[DATA_BITS+1] = (^data) ^ (PARITY_ODD != 0);
    end
  end

  // A load coinciding with a tick is a back-to-back reload: the start bit goes
  // out on that same tick, so the counter resumes at 1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame  <= '0;
      cnt    <= '0;
      tx_bit <= 1'b1;
    end else if (load && tick) begin
      frame  <= {1'b1, frame_init[NBITS-1:1]};
      tx_bit <= frame_init[0];
      cnt    <= CW'(1);
    end else if (load) begin
      frame <= frame_init;
      cnt   <= '0;
    end else if (tick) begin
      if (cnt == END_IDX) begin
        cnt <= '0;
      end else begin
        tx_bit <= frame[0];
        frame  <= {1'b1, frame[NBITS-1:1]};
        cnt    <= cnt + 1'b1;
      end
    end
  end

  assign last = (cnt == END_IDX);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer top: valid/ready holding register, IDLE/SEND FSM and
// baud-generator enable around the frame shift register.
module uart_tx_framer
  import uart_tx_framer_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = DEF_STOP_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_bps,
  output logic                 bps_start,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  state_t               state;
  state_t               state_nxt;
  logic [DATA_BITS-1:0] hold_data;
  logic                 hold_full;
  logic                 shift_tick;
  logic                 frame_end;
  logic                 load;
  logic                 last;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hold_full) state_nxt = SEND;
      SEND:    if (frame_end && !hold_full) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shift_tick = (state == SEND) && clk_bps;
    frame_end  = shift_tick && last;
    load       = hold_full && ((state == IDLE) || frame_end);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_data <= '0;
      hold_full <= 1'b0;
    end else if (tx_valid && tx_ready) begin
      hold_data <= tx_data;
      hold_full <= 1'b1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  // bps_start follows SEND one clock late, dropping together with the final
  // frame-end tick when nothing is waiting to be reloaded.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bps_start  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      bps_start  <= (state == SEND) && !(frame_end && !hold_full);
      frame_done <= frame_end;
    end
  end

  uart_tx_shift #(
    .DATA_BITS (DATA_BITS),
    .PARITY_EN (PARITY_EN),
    .PARITY_ODD(PARITY_ODD),
    .STOP_BITS (STOP_BITS)
  ) u_shift (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .tick  (shift_tick),
    .data  (hold_data),
    .tx_bit(tx),
    .last  (last)
  );

  assign tx_ready = !hold_full;
  assign busy     = (state == SEND) || hold_full;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: four parameterisations, a bit-level scoreboard
// monitor, a table of reference frames and hand-written corner sequences.
module tb_uart_tx_framer;

  localparam int NDUT = 4;
  localparam int NB  [NDUT] = '{10, 11, 11, 11};
  localparam int PEN [NDUT] = '{0, 1, 1, 0};
  localparam int POD [NDUT] = '{0, 0, 1, 0};
  localparam int LIMIT = 3000;

  logic       clk = 1'b0;
  logic       rst;
  logic       rand_mode;
  logic       rand_tick;
  logic       tick  [NDUT];
  logic       bps   [NDUT];
  logic       txs   [NDUT];
  logic       busy  [NDUT];
  logic       done  [NDUT];
  logic       ready [NDUT];
  logic       valid [NDUT];
  logic [7:0] data  [NDUT];
  logic [2:0] bcnt  [NDUT];

  int          n_chk = 0;
  int          n_fail = 0;
  int          mon_k       [NDUT];
  int          frames_done [NDUT];
  logic [15:0] rx_frame    [NDUT];
  bit q0[$], q1[$], q2[$], q3[$];

  always #5 clk = ~clk;

  uart_tx_framer u_d0 (
    .clk(clk), .rst(rst), .clk_bps(tick[0]), .bps_start(bps[0]), .tx_data(data[0]),
    .tx_valid(valid[0]), .tx_ready(ready[0]), .tx(txs[0]), .busy(busy[0]), .frame_done(done[0]));
  uart_tx_framer #(.PARITY_EN(1), .PARITY_ODD(0)) u_d1 (
    .clk(clk), .rst(rst), .clk_bps(tick[1]), .bps_start(bps[1]), .tx_data(data[1]),
    .tx_valid(valid[1]), .tx_ready(ready[1]), .tx(txs[1]), .busy(busy[1]), .frame_done(done[1]));
  uart_tx_framer #(.PARITY_EN(1), .PARITY_ODD(1)) u_d2 (
    .clk(clk), .rst(rst), .clk_bps(tick[2]), .bps_start(bps[2]), .tx_data(data[2]),
    .tx_valid(valid[2]), .tx_ready(ready[2]), .tx(txs[2]), .busy(busy[2]), .frame_done(done[2]));
  uart_tx_framer #(.STOP_BITS(2)) u_d3 (
    .clk(clk), .rst(rst), .clk_bps(tick[3]), .bps_start(bps[3]), .tx_data(data[3]),
    .tx_valid(valid[3]), .tx_ready(ready[3]), .tx(txs[3]), .busy(busy[3]), .frame_done(done[3]));

  // Baud generator model: one tick every 7 clocks while enabled.
  always @(posedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (bps[i] !== 1'b1) bcnt[i] <= 3'd0;
      else                 bcnt[i] <= (bcnt[i] == 3'd6) ? 3'd0 : bcnt[i] + 3'd1;
    end
  end

  always @(negedge clk) rand_tick <= 1'($urandom_range(0, 1));

  always_comb begin
    for (int i = 0; i < NDUT; i++) begin
      tick[i] = rand_mode ? rand_tick : (bps[i] === 1'b1 && bcnt[i] == 3'd6);
    end
  end

  task automatic check(input string name, input int i, input logic [15:0] act,
                       input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, i, act, exp, $time);
    end
  endtask

  task automatic q_push(input int i, input bit b);
    case (i)
      0: q0.push_back(b);
      1: q1.push_back(b);
      2: q2.push_back(b);
      default: q3.push_back(b);
    endcase
  endtask

  task automatic q_pop(input int i, output bit b, output bit ok);
    ok = 1'b0;
    b  = 1'b0;
    case (i)
      0: if (q0.size() > 0) begin b = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin b = q1.pop_front(); ok = 1'b1; end
      2: if (q2.size() > 0) begin b = q2.pop_front(); ok = 1'b1; end
      default: if (q3.size() > 0) begin b = q3.pop_front(); ok = 1'b1; end
    endcase
  endtask

  task automatic q_clear(input int i);
    case (i)
      0: q0.delete();
      1: q1.delete();
      2: q2.delete();
      default: q3.delete();
    endcase
  endtask

  function automatic int q_size(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic bit model_bit(input int i, input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9 && PEN[i] != 0) return (^d) ^ (POD[i] != 0);
    return 1'b1;
  endfunction

  task automatic pop_check(input int i, input int k);
    bit b, ok;
    q_pop(i, b, ok);
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_bit dut%0d: got tx=%0b with no frame expected at %0t",
               i, txs[i], $time);
    end else begin
      check("tx_bit", i, 16'(txs[i]), 16'(b));
    end
    rx_frame[i][k] = txs[i];
  endtask

  // Scoreboard monitor: accepts push the model frame, each tick pops one bit.
  initial begin : monitor
    logic       t_s [NDUT];
    logic       a_s [NDUT];
    logic [7:0] d_s [NDUT];
    logic       r_s;
    for (int i = 0; i < NDUT; i++) begin
      mon_k[i] = 0;
      frames_done[i] = 0;
      rx_frame[i] = '0;
    end
    forever begin
      @(posedge clk);
      r_s = rst;
      for (int i = 0; i < NDUT; i++) begin
        t_s[i] = (tick[i] === 1'b1) && (bps[i] === 1'b1);
        a_s[i] = (valid[i] === 1'b1) && (ready[i] === 1'b1);
        d_s[i] = data[i];
      end
      #1;
      for (int i = 0; i < NDUT; i++) begin
        if (r_s !== 1'b1) begin
          q_clear(i);
          mon_k[i] = 0;
        end else begin
          if (a_s[i]) for (int k = 0; k < NB[i]; k++) q_push(i, model_bit(i, d_s[i], k));
          if (t_s[i] && mon_k[i] >= NB[i]) begin
            check("frame_done_pulse", i, 16'(done[i]), 16'd1);
            frames_done[i]++;
            if (bps[i] === 1'b1) begin
              pop_check(i, 0);
              mon_k[i] = 1;
            end else begin
              mon_k[i] = 0;
            end
          end else begin
            check("frame_done_quiet", i, 16'(done[i]), 16'd0);
            if (t_s[i]) begin
              pop_check(i, mon_k[i]);
              mon_k[i]++;
            end
          end
        end
      end
    end
  end

  task automatic send(input int i, input logic [7:0] b);
    bit got = 1'b0;
    @(negedge clk);
    data[i]  = b;
    valid[i] = 1'b1;
    for (int c = 0; c < LIMIT && !got; c++) begin
      @(posedge clk);
      if (ready[i] === 1'b1) got = 1'b1;
    end
    #1;
    valid[i] = 1'b0;
    data[i]  = ~b;
    check("accept_seen", i, 16'(got), 16'd1);
  endtask

  task automatic wait_frame(input int i, input int prev);
    bit got = 1'b0;
    for (int c = 0; c < LIMIT && !got; c++) begin
      @(negedge clk);
      if (frames_done[i] != prev) got = 1'b1;
    end
    check("frame_end_seen", i, 16'(got), 16'd1);
  endtask

  typedef struct {
    int          dut;
    logic [7:0]  data;
    logic [15:0] frame;
  } vec_t;

  vec_t vecs [7];

  initial begin : main
    int prev;
    int run;
    bit got;
    vecs[0] = '{0, 8'hA5, 16'h034A};
    vecs[1] = '{1, 8'h07, 16'h060E};
    vecs[2] = '{2, 8'h07, 16'h040E};
    vecs[3] = '{0, 8'h00, 16'h0200};
    vecs[4] = '{0, 8'hFF, 16'h03FE};
    vecs[5] = '{1, 8'h00, 16'h0400};
    vecs[6] = '{3, 8'h3C, 16'h0678};

    rst = 1'b0;
    rand_mode = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      valid[i] = 1'b0;
      data[i]  = 8'h00;
    end

    // Reset held, then idle with random ticks.
    repeat (4) @(negedge clk);
    for (int i = 0; i < NDUT; i++)
      check("reset_state", i, 16'({txs[i], bps[i], busy[i], done[i]}), 16'b1000);
    rst = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      for (int i = 0; i < NDUT; i++)
        check("idle_state", i, 16'({txs[i], bps[i], busy[i], ready[i]}), 16'b1001);
    end
    rand_mode = 1'b0;

    // Reference frames.
    for (int v = 0; v < 7; v++) begin
      prev = frames_done[vecs[v].dut];
      send(vecs[v].dut, vecs[v].data);
      wait_frame(vecs[v].dut, prev);
      check("frame_bits", vecs[v].dut, rx_frame[vecs[v].dut], vecs[v].frame);
      @(negedge clk);
      check("idle_after", vecs[v].dut, 16'({bps[vecs[v].dut], busy[vecs[v].dut]}), 16'd0);
    end

    // Back-to-back 0x55 then 0xAA: ready held low, no gap, reload start bit.
    prev = frames_done[0];
    send(0, 8'h55);
    send(0, 8'hAA);
    got = 1'b0;
    for (int c = 0; c < LIMIT && !got; c++) begin
      @(negedge clk);
      if (frames_done[0] != prev) got = 1'b1;
      else check("held_ready_bps", 0, 16'({ready[0], bps[0]}), 16'b01);
    end
    check("b2b_first_end", 0, 16'(got), 16'd1);
    check("b2b_reload", 0, 16'({ready[0], bps[0], txs[0]}), 16'b110);
    prev = frames_done[0];
    got = 1'b0;
    for (int c = 0; c < LIMIT && !got; c++) begin
      @(negedge clk);
      if (frames_done[0] != prev) got = 1'b1;
      else check("b2b_bps_high", 0, 16'(bps[0]), 16'd1);
    end
    check("b2b_second_end", 0, 16'(got), 16'd1);
    check("b2b_second_bits", 0, rx_frame[0], 16'h0354);
    check("b2b_bps_low", 0, 16'(bps[0]), 16'd0);

    // Reset after tick 4 with a byte held: frame aborted, held byte dropped.
    send(0, 8'h33);
    send(0, 8'hCC);
    got = 1'b0;
    for (int c = 0; c < LIMIT && !got; c++) begin
      @(negedge clk);
      if (mon_k[0] == 5) got = 1'b1;
    end
    check("tick4_reached", 0, 16'(got), 16'd1);
    prev = frames_done[0];
    rst = 1'b0;
    @(negedge clk);
    check("abort_state", 0, 16'({txs[0], bps[0], busy[0], ready[0]}), 16'b1001);
    rst = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      check("abort_quiet", 0, 16'({txs[0], bps[0], busy[0]}), 16'b100);
    end
    check("abort_no_done", 0, 16'(frames_done[0]), 16'(prev));

    // Two stop bits, back to back: 2 bit periods (14 clocks) high between frames.
    prev = frames_done[3];
    send(3, 8'h0F);
    send(3, 8'hF0);
    run = 0;
    got = 1'b0;
    for (int c = 0; c < LIMIT && !got; c++) begin
      @(negedge clk);
      if (frames_done[3] != prev) got = 1'b1;
      else if (txs[3] === 1'b1) run++;
      else run = 0;
    end
    check("stop2_first_end", 3, 16'(got), 16'd1);
    check("stop2_gap_clocks", 3, 16'(run), 16'd14);
    check("stop2_start_bit", 3, 16'({bps[3], txs[3]}), 16'b10);
    prev = frames_done[3];
    wait_frame(3, prev);
    check("stop2_second_bits", 3, rx_frame[3], 16'h07E0);

    repeat (20) @(negedge clk);
    for (int i = 0; i < NDUT; i++) check("queue_drained", i, 16'(q_size(i)), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
